bank_arbiter: RTL and testbench

BANK_ARBITER -- requirements
Module: bank_arbiter

---
 rtl/bank_arbiter.sv | 152 +++++++++++++++
 tb/tb_bank_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bank_arbiter.sv
// Two-client round-robin owner arbiter for a single memory bank with in-order read-return routing.
// Optional BANK_ARBITER_STATS_EN adds per-client command and read-stall counters.
module bank_arbiter #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BE_WIDTH      = 16,
  parameter int MAX_BURST     = 16,
  parameter int RD_DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 creq,
  input  logic [1:0]                 cce,
  input  logic [1:0]                 cw,
  input  logic [2*ADDRESS_WIDTH-1:0] ca,
  input  logic [2*DATA_WIDTH-1:0]    cd,
  input  logic [2*BE_WIDTH-1:0]      cbe,
  output logic [1:0]                 cgnt,
  output logic                       crdy,
  output logic [1:0]                 cvalid,
  output logic [DATA_WIDTH-1:0]      cq,
  input  logic                       mready,
  input  logic                       mvalid,
  input  logic [DATA_WIDTH-1:0]      mq,
  output logic                       mreq,
  output logic                       mce,
  output logic                       mw,
  output logic [ADDRESS_WIDTH-1:0]   ma,
  output logic [DATA_WIDTH-1:0]      md,
  output logic [BE_WIDTH-1:0]        mbe,
  output logic [1:0]                 mtag
`ifdef BANK_ARBITER_STATS_EN
  ,
  output logic [31:0]                stat_cmd0,
  output logic [31:0]                stat_cmd1,
  output logic [31:0]                stat_rd_stall
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q;
  logic [1:0]      gnt_q;
  logic            last_q;
  logic [BW-1:0]   burst_q, burst_d;
  logic [RD_DEPTH-1:0] fifo_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   rd_cnt_q;

  logic owning, own_id, cur_req, oth_req, full, push, pop, leave, idle_pick;

  assign owning  = (state_q != IDLE);
  assign own_id  = (state_q == OWN1);
  assign cur_req = creq[own_id];
  assign oth_req = creq[~own_id];
  assign full    = (rd_cnt_q == CW'(RD_DEPTH));

  assign cgnt = gnt_q;
  assign crdy = mready & owning & ~full;
  assign mce  = crdy & |(cce & gnt_q);
  assign mw   = cw[own_id];
  assign ma   = ca[own_id*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign md   = cd[own_id*DATA_WIDTH +: DATA_WIDTH];
  assign mbe  = cbe[own_id*BE_WIDTH +: BE_WIDTH];
  assign mtag = 2'b00;
  assign mreq = owning | (rd_cnt_q != '0);

  // Count saturates so an unchallenged owner can stream indefinitely.
  assign burst_d   = (mce && burst_q != BW'(MAX_BURST)) ? burst_q + 1'b1 : burst_q;
  assign leave     = ~cur_req | (oth_req & (burst_d == BW'(MAX_BURST)));
  assign idle_pick = (creq == 2'b11) ? ~last_q : creq[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          burst_q <= '0;
          if (creq != 2'b00) begin
            state_q <= idle_pick ? OWN1 : OWN0;
            gnt_q   <= idle_pick ? 2'b10 : 2'b01;
            last_q  <= idle_pick;
          end
        end
        default: begin
          if (leave) begin
            burst_q <= '0;
            if (oth_req) begin
              state_q <= own_id ? OWN0 : OWN1;
              gnt_q   <= own_id ? 2'b01 : 2'b10;
              last_q  <= ~own_id;
            end else begin
              state_q <= IDLE;
              gnt_q   <= 2'b00;
            end
          end else begin
            burst_q <= burst_d;
          end
        end
      endcase
    end
  end

  // Route FIFO: one owner-ID bit per outstanding read, popped in issue order.
  assign push   = mce & ~mw;
  assign pop    = mvalid & (rd_cnt_q != '0);
  assign cvalid = pop ? (fifo_q[rd_ptr_q] ? 2'b10 : 2'b01) : 2'b00;
  assign cq     = mq;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= own_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   rd_cnt_q <= rd_cnt_q + 1'b1;
        2'b01:   rd_cnt_q <= rd_cnt_q - 1'b1;
        default: rd_cnt_q <= rd_cnt_q;
      endcase
    end
  end

`ifdef BANK_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cmd0     <= '0;
      stat_cmd1     <= '0;
      stat_rd_stall <= '0;
    end else begin
      if (mce & ~own_id) stat_cmd0 <= stat_cmd0 + 1'b1;
      if (mce &  own_id) stat_cmd1 <= stat_cmd1 + 1'b1;
      if (full & owning) stat_rd_stall <= stat_rd_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bank_arbiter.sv
// Randomized bench for bank_arbiter against a queue-based ownership/read-routing model.
module tb_bank_arbiter;
  localparam int DW = 32, AW = 16, BEW = 4, MB = 4, RD = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] creq = '0, cce = '0, cw = '0;
  logic [2*AW-1:0] ca = '0;
  logic [2*DW-1:0] cd = '0;
  logic [2*BEW-1:0] cbe = '0;
  logic [1:0] cgnt, cvalid, mtag;
  logic crdy, mready = 1'b0, mvalid = 1'b0, mreq, mce, mw;
  logic [DW-1:0] cq, md, mq = '0;
  logic [AW-1:0] ma;
  logic [BEW-1:0] mbe;
`ifdef BANK_ARBITER_STATS_EN
  logic [31:0] stat_cmd0, stat_cmd1, stat_rd_stall;
`endif

  bank_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BE_WIDTH(BEW),
                 .MAX_BURST(MB), .RD_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .creq(creq), .cce(cce), .cw(cw), .ca(ca), .cd(cd), .cbe(cbe),
    .cgnt(cgnt), .crdy(crdy), .cvalid(cvalid), .cq(cq), .mready(mready), .mvalid(mvalid),
    .mq(mq), .mreq(mreq), .mce(mce), .mw(mw), .ma(ma), .md(md), .mbe(mbe), .mtag(mtag)
`ifdef BANK_ARBITER_STATS_EN
    , .stat_cmd0(stat_cmd0), .stat_cmd1(stat_cmd1), .stat_rd_stall(stat_rd_stall)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  bit live = 0;

  // Model: owner is -1 when idle; q holds the client ID of each outstanding read.
  int own = -1, last = 1, burst = 0;
  int q[$];
  int n0 = 0, n1 = 0, nst = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input logic [1:0] rq, input logic [1:0] ce,
                     input logic [1:0] w, input bit mr, input bit mv);
    bit full, rdy, acc, pp;
    int nxt, oth;
    @(negedge clk);
    rst = r; creq = rq; cce = ce; cw = w; mready = mr; mvalid = mv;
    ca = $urandom; cd = {$urandom, $urandom}; cbe = $urandom; mq = $urandom;
    #1;
    full = (q.size() == RD);
    rdy  = mr && own >= 0 && !full;
    acc  = rdy && cce[own];
    pp   = mv && q.size() > 0;
    if (live) begin
      chk("cgnt", cgnt, own < 0 ? 2'b00 : (2'b01 << own));
      chk("crdy", crdy, rdy);
      chk("mce", mce, acc);
      chk("mreq", mreq, own >= 0 || q.size() > 0);
      chk("cvalid", cvalid, pp ? (2'b01 << q[0]) : 2'b00);
      chk("mtag", mtag, 2'b00);
      if (acc) begin
        chk("mw", mw, cw[own]);
        chk("ma", ma, ca[own*AW +: AW]);
        chk("md", md, cd[own*DW +: DW]);
        chk("mbe", mbe, cbe[own*BEW +: BEW]);
      end
      if (pp) chk("cq", cq, mq);
`ifdef BANK_ARBITER_STATS_EN
      chk("stat_cmd0", stat_cmd0, n0);
      chk("stat_cmd1", stat_cmd1, n1);
      chk("stat_rd_stall", stat_rd_stall, nst);
`endif
    end
    @(posedge clk);
    live = 1;
    if (r) begin
      own = -1; last = 1; burst = 0; q.delete(); n0 = 0; n1 = 0; nst = 0;
    end else begin
      if (acc) begin
        if (own == 0) n0++; else n1++;
      end
      if (full && own >= 0) nst++;
      if (acc && !cw[own]) q.push_back(own);
      if (pp) void'(q.pop_front());
      if (own < 0) begin
        nxt = (rq == 2'b11) ? 1 - last : (rq[0] ? 0 : (rq[1] ? 1 : -1));
      end else begin
        oth = 1 - own;
        burst += acc;
        if (!rq[own]) nxt = rq[oth] ? oth : -1;
        else if (rq[oth] && burst >= MB) nxt = oth;
        else nxt = own;
      end
      if (nxt != own) begin
        burst = 0;
        if (nxt >= 0) last = nxt;
      end
      own = nxt;
    end
  endtask

  initial begin
    logic [1:0] rq;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);               // stray mvalid on empty FIFO
    // tie from reset: client 0 first, then hand over when it drops
    cyc(0, 2'b11, 0, 0, 1, 0);
    cyc(0, 2'b11, 0, 0, 1, 0);
    cyc(0, 2'b10, 0, 0, 1, 0);
    cyc(0, 2'b10, 0, 0, 1, 0);
    cyc(0, 2'b00, 0, 0, 1, 0);
    // client 0 three reads, client 1 two reads, then five returns
    cyc(0, 2'b01, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'b01, 2'b01, 2'b00, 1, 0);
    cyc(0, 2'b10, 0, 0, 1, 0);
    cyc(0, 2'b10, 2'b10, 2'b00, 1, 0);   // fills FIFO
    cyc(0, 2'b10, 2'b10, 2'b00, 1, 0);   // blocked while full
    cyc(0, 2'b10, 2'b10, 2'b00, 1, 1);   // pop frees a slot
    cyc(0, 2'b10, 2'b10, 2'b00, 1, 0);
    cyc(0, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 2'b00, 0, 0, 1, 1);
    // reset with reads outstanding, then a late mvalid
    cyc(0, 2'b01, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'b01, 2'b01, 2'b00, 1, 0);
    cyc(1, 2'b00, 0, 0, 1, 0);
    cyc(0, 2'b00, 0, 0, 1, 1);
    cyc(0, 2'b00, 0, 0, 1, 1);
    // both streaming writes: ownership alternates every MB commands
    for (int i = 0; i < 24; i++) cyc(0, 2'b11, 2'b11, 2'b11, 1, 0);
    cyc(0, 2'b00, 0, 0, 1, 0);
    // random traffic
    rq = 2'b00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) rq[0] = ~rq[0];
      if ($urandom_range(7) == 0) rq[1] = ~rq[1];
      cyc($urandom_range(199) == 0, rq, $urandom, $urandom,
          $urandom_range(4) != 0, $urandom_range(4) < 2);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
